// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter control slice.
//   state_t     : fetch sequencer state encoding
//   PCM_*       : PC_MUX codes driven to the program counter
//   SRC_*       : direct-target source codes (PC_DIRECT_CH)
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] PCM_HOLD   = 2'b00;
  localparam logic [1:0] PCM_DIRECT = 2'b01;
  localparam logic [1:0] PCM_INC    = 2'b10;
  localparam logic [1:0] PCM_ZERO   = 2'b11;

  localparam logic [1:0] SRC_RESULT = 2'b00;
  localparam logic [1:0] SRC_IMM    = 2'b01;
  localparam logic [1:0] SRC_RD     = 2'b10;
  localparam logic [1:0] SRC_ZERO   = 2'b11;

endpackage

// File: rtl/pc_fetch_wdog.sv
// Fetch wait counter. Counts FETCH cycles without an ack and flags a timeout
// in the cycle the count reaches TIMEOUT_CYCLES with no ack present.
// Ports:
//   clk, reset   : clock, async active-low reset
//   in_fetch     : sequencer is in FETCH this cycle
//   ack          : imem_ack this cycle
//   timeout      : combinational, FETCH must restart at PC 0 this cycle
module pc_fetch_wdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic in_fetch,
  input  logic ack,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYCLES);

  logic [3:0] cnt;

  assign timeout = in_fetch & ~ack & (cnt == LIMIT);

  // Held at zero outside FETCH, so every FETCH entry starts from 0.
  // A timeout restarts the fetch, so the count restarts too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          cnt <= '0;
    else if (!in_fetch || ack || timeout) cnt <= '0;
    else                                 cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch/branch sequencer for the 10-bit program counter.
// Drives PC_MUX / PC_DIRECT_CH, runs the imem req/ack handshake, latches the
// fetched instruction and counts retired instructions.
// Optional fetch timeout: define PC_FETCH_CTRL_TIMEOUT_EN.
// Ports:
//   clk, reset     : clock, async active-low reset
//   imem_ack/rdata : instruction memory response (used in FETCH only)
//   stall          : execute not ready, hold current instruction
//   halt_req       : halt, leave only by reset
//   jump/br_taken  : direct load with br_src as target select
//   imem_req       : fetch request (Moore)
//   PC_MUX         : 00 hold, 01 direct, 10 PC+2, 11 zero (combinational)
//   PC_DIRECT_CH   : direct-target select, 00 unless PC_MUX=01
//   instr          : latched instruction, instr_valid in EXEC (Moore)
//   retired_cnt    : instructions leaving EXEC, wraps at 16 bits
//   fetch_err      : sticky fetch timeout flag (0 without timeout feature)
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        jump,
  input  logic        br_taken,
  input  logic [1:0]  br_src,
  output logic        imem_req,
  output logic [1:0]  PC_MUX,
  output logic [1:0]  PC_DIRECT_CH,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] retired_cnt,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..15");
  end

  state_t state, state_n;
  logic   timeout;

`ifdef PC_FETCH_CTRL_TIMEOUT_EN
  pc_fetch_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .in_fetch (state == ST_FETCH),
    .ack      (imem_ack),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       fetch_err <= 1'b0;
    else if (timeout) fetch_err <= 1'b1;
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_EXEC);

  always_comb begin
    state_n      = state;
    PC_MUX       = PCM_HOLD;
    PC_DIRECT_CH = SRC_RESULT;
    case (state)
      ST_INIT: begin
        PC_MUX  = PCM_ZERO;
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        // ack wins over a timeout landing in the same cycle
        if (imem_ack)     state_n = ST_EXEC;
        else if (timeout) PC_MUX  = PCM_ZERO;
      end
      ST_EXEC: begin
        if (stall) begin
          // hold; other requests re-evaluated next cycle
        end else if (halt_req) begin
          state_n = ST_HALT;
        end else if (jump || br_taken) begin
          PC_MUX       = PCM_DIRECT;
          PC_DIRECT_CH = br_src;
          state_n      = ST_FETCH;
        end else begin
          PC_MUX  = PCM_INC;
          state_n = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      instr       <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ST_FETCH && imem_ack) instr <= imem_rdata;
      if (state == ST_EXEC && !stall)    retired_cnt <= retired_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch/branch sequencer for the 10-bit program counter block. It drives the counter's next-PC select (`PC_MUX`) and direct-target select (`PC_DIRECT_CH`). It also runs the instruction-memory request/acknowledge handshake, latches the fetched 16-bit instruction and hands it to decode/execute. It sits between the instruction memory, the program counter and the execute stage, and is the only writer of the PC select lines.

## Interface
- `TIMEOUT_CYCLES`, default 15: fetch wait limit, used only with the timeout feature; range 1..15.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset asserted).
- `imem_ack`  in  1: instruction memory data valid; sampled only in FETCH.
- `imem_rdata`  in  16: instruction word; captured when `imem_ack`=1 in FETCH.
- `stall`  in  1: execute stage not ready; holds the current instruction.
- `halt_req`  in  1: decoded halt instruction.
- `jump`  in  1: unconditional control transfer.
- `br_taken`  in  1: conditional branch resolved taken.
- `br_src`  in  2: direct target source, passed to `PC_DIRECT_CH` (00 RESULT, 01 instr imm, 10 register, 11 zero).
- `imem_req`  out  1: fetch request.
- `PC_MUX`  out  2: 00 hold, 01 direct, 10 PC+2, 11 zero.
- `PC_DIRECT_CH`  out  2: direct-target select.
- `instr`  out  16: latched instruction register.
- `instr_valid`  out  1: `instr` is valid for execute.
- `retired_cnt`  out  16: count of instructions that have left EXEC.
- `fetch_err`  out  1: sticky fetch timeout flag.

## Operation
- States: INIT, FETCH, EXEC, HALT.
- INIT
  - `PC_MUX`=11 (PC loads 0); next state FETCH.
- FETCH
  - Outputs: `imem_req`=1, `PC_MUX`=00.
  - On `imem_ack`: `instr`<=`imem_rdata`, next state EXEC.
  - An `imem_ack` seen in any other state is ignored.
- EXEC
  - `instr_valid`=1. Priority, highest first:
  - `stall`: `PC_MUX`=00, stay in EXEC, `instr` unchanged.
  - `halt_req`: `PC_MUX`=00, next state HALT.
  - `jump | br_taken`: `PC_MUX`=01, `PC_DIRECT_CH`=`br_src`, next state FETCH.
  - Otherwise: `PC_MUX`=10, next state FETCH.
- HALT
  - `PC_MUX`=00, `imem_req`=0, `instr_valid`=0.
  - Left only by reset.
- `PC_DIRECT_CH`=00 whenever `PC_MUX`≠01.
- `retired_cnt`
  - Increments by 1 on every non-stalled EXEC exit, halt included.
  - 16-bit, wraps 0xFFFF→0x0000.
- Output decoding
  - `PC_MUX` and `PC_DIRECT_CH` are combinational from state and inputs; the PC register consumes them on the same edge.
  - `imem_req` and `instr_valid` are Moore outputs, decoded from state only.

## Timing
- While `reset`=0:
  - State is INIT.
  - `instr`=0, `instr_valid`=0, `imem_req`=0, `retired_cnt`=0, `fetch_err`=0.
  - `PC_MUX`=11, `PC_DIRECT_CH`=00.
- Reset asserted mid-fetch or mid-execute aborts immediately. A pending ack is discarded.
- First `imem_req` appears the cycle after the first edge with `reset`=1.
- Minimum throughput: 2 cycles per instruction, when `imem_ack` arrives in the first FETCH cycle.
- `instr` is valid from the first EXEC cycle. The PC update takes effect at the edge that leaves EXEC, so the next FETCH presents the new address.
- Simultaneous `stall` and `halt_req`/`jump`: stall wins. The other inputs are re-evaluated each stalled cycle.
- `jump` and `br_taken` together: a single direct load.

## Configuration
- `PC_FETCH_CTRL_TIMEOUT_EN` defined:
  - A 4-bit wait counter clears on FETCH entry and counts each FETCH cycle without ack.
  - When it equals `TIMEOUT_CYCLES` with no ack in that cycle:
    - `PC_MUX`=11 for that cycle.
    - `fetch_err` sets and stays set until reset.
    - FETCH restarts at PC 0.
- Not defined: FETCH waits indefinitely; `fetch_err` is tied 0; no counter logic.

## Structure
- Shared package `pc_ctrl_pkg` holds:
  - state encoding;
  - `PC_MUX` codes: HOLD, DIRECT, INC, ZERO;
  - direct-source codes: RESULT, IMM, RD, ZERO.
- One natural sub-module, `pc_fetch_wdog`: the timeout counter. It is instantiated only under the macro.

## Test plan
- Reset release, `imem_ack` tied 1, no branches: `PC_MUX` sequence 11, 00, 10, 00, 10…; `retired_cnt`=3 after 7 cycles.
- EXEC with `jump`=1, `br_src`=01: `PC_MUX`=01, `PC_DIRECT_CH`=01 for exactly one cycle, then FETCH.
- EXEC with `stall`=1 for 3 cycles plus `br_taken`=1: `PC_MUX`=00 ×3, `instr` stable; on release `PC_MUX`=01.
- `halt_req` in EXEC: HALT entered; `imem_req`=0 forever; `retired_cnt` incremented once; only reset recovers.
- Macro on, `TIMEOUT_CYCLES`=4, `imem_ack`=0: after 4 FETCH cycles `PC_MUX`=11 and `fetch_err`=1 (sticky); a later ack proceeds normally.
- `reset` pulsed low during FETCH with ack pending: outputs at reset values, `instr`=0, ack ignored.
